ps2_pad: RTL and testbench

PS/2 keyboard receiver and decoder. It turns keystrokes into a 12-bit SNES-style button word that can be wired directly to the `plyra_input`/`plyrb_input` consumer in the system top, as an alternative to a physical SNES pad. It sits upstream of the memory controller's player-input registers and owns the PS/2 clock/data pins.

---
 rtl/ps2_pad.sv | 174 +++++++++++++++++
 tb/tb_ps2_pad.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_pad.sv
// ps2_pad - PS/2 keyboard receiver and SNES-style button decoder.
//
// Receives 11-bit PS/2 frames (start, D0..D7 LSB first, odd parity, stop),
// validates them, and tracks E0 (extended) / F0 (break) prefixes so that
// make/break codes of a fixed key set drive a 12-bit button word.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk fall before a frame aborts
// Ports:
//   clk          system clock
//   rst_btn      asynchronous active-low reset
//   ps2_clk      PS/2 clock pin (asynchronous, idles high)
//   ps2_data     PS/2 data pin (asynchronous, idles high)
//   plyr_input   button state, 1 = pressed
//                (0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left,
//                 7 Right, 8 A, 9 X, 10 L, 11 R)
//   scan_code    last correctly received byte
//   frame_valid  one-cycle pulse when a byte passes all checks
//   frame_err    one-cycle pulse on framing/parity/stop error or timeout
module ps2_pad #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_btn,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] plyr_input,
    output logic [7:0]  scan_code,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // Bit 0 carries ps2_clk, bit 1 carries ps2_data.
    logic [1:0]    sync1_reg;
    logic [1:0]    sync2_reg;
    logic          clk_prev_reg;
    logic          fall;
    logic          data_s;

    state_t        state_reg;
    logic [3:0]    bit_cnt_reg;
    logic [9:0]    shift_reg;   // D0..D7, parity, stop once complete
    logic [TW-1:0] tcnt_reg;
    logic          ext_reg;
    logic          brk_reg;
    logic [4:0]    lookup;      // {hit, button index}

    assign fall   = clk_prev_reg & ~sync2_reg[0];
    assign data_s = sync2_reg[1];

    // Key map: returns {hit, button index} for a byte under the current ext flag.
    function automatic logic [4:0] key_lookup(input logic e, input logic [7:0] code);
        logic [4:0] r;
        r = 5'd0;
        if (!e) begin
            case (code)
                8'h1A:   r = {1'b1, 4'd0};
                8'h1C:   r = {1'b1, 4'd1};
                8'h59:   r = {1'b1, 4'd2};
                8'h5A:   r = {1'b1, 4'd3};
                8'h22:   r = {1'b1, 4'd8};
                8'h1B:   r = {1'b1, 4'd9};
                8'h15:   r = {1'b1, 4'd10};
                8'h1D:   r = {1'b1, 4'd11};
                default: r = 5'd0;
            endcase
        end else begin
            case (code)
                8'h75:   r = {1'b1, 4'd4};
                8'h72:   r = {1'b1, 4'd5};
                8'h6B:   r = {1'b1, 4'd6};
                8'h74:   r = {1'b1, 4'd7};
                default: r = 5'd0;
            endcase
        end
        return r;
    endfunction

    assign lookup = key_lookup(ext_reg, shift_reg[7:0]);

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync1_reg    <= 2'b11;
            sync2_reg    <= 2'b11;
            clk_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= {ps2_data, ps2_clk};
            sync2_reg    <= sync1_reg;
            clk_prev_reg <= sync2_reg[0];
        end
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 10'd0;
            tcnt_reg    <= '0;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
            plyr_input  <= 12'd0;
            scan_code   <= 8'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            // A fall always clears the counter, so it beats a same-cycle timeout.
            if (fall)
                tcnt_reg <= '0;
            else if (state_reg == RECV && tcnt_reg != T_LAST)
                tcnt_reg <= tcnt_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        if (!data_s) begin
                            state_reg   <= RECV;
                            bit_cnt_reg <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                            ext_reg   <= 1'b0;
                            brk_reg   <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (fall) begin
                        shift_reg   <= {data_s, shift_reg[9:1]};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd10)
                            state_reg <= CHECK;
                    end else if (tcnt_reg == T_LAST) begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= 4'd0;
                        frame_err   <= 1'b1;
                        ext_reg     <= 1'b0;
                        brk_reg     <= 1'b0;
                    end
                end
                CHECK: begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= 4'd0;
                    if ((^shift_reg[8:0]) && shift_reg[9]) begin
                        scan_code   <= shift_reg[7:0];
                        frame_valid <= 1'b1;
                        if (shift_reg[7:0] == 8'hE0) begin
                            ext_reg <= 1'b1;
                        end else if (shift_reg[7:0] == 8'hF0) begin
                            brk_reg <= 1'b1;
                        end else begin
                            if (lookup[4])
                                plyr_input[lookup[3:0]] <= ~brk_reg;
                            ext_reg <= 1'b0;
                            brk_reg <= 1'b0;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        ext_reg   <= 1'b0;
                        brk_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_pad.sv
// tb_ps2_pad - directed bench for ps2_pad: a table of byte frames with
// expected button word / scan code / pulse kind, plus hand-written
// sequences for asynchronous reset mid-frame and the receive timeout.
module tb_ps2_pad;

    logic        clk;
    logic        rst_btn;
    logic        ps2_clk;
    logic        ps2_data;
    logic [11:0] plyr_input;
    logic [7:0]  scan_code;
    logic        frame_valid;
    logic        frame_err;

    int checks;
    int errors;
    int valid_cnt;
    int err_cnt;
    int overlap_cnt;

    ps2_pad #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst_btn    (rst_btn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .plyr_input (plyr_input),
        .scan_code  (scan_code),
        .frame_valid(frame_valid),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err)   err_cnt++;
        if (frame_valid && frame_err) overlap_cnt++;
    end

    typedef struct {
        logic [7:0]  code;
        logic        bad_par;
        logic [11:0] exp_plyr;
        logic [7:0]  exp_scan;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    // Drive the first n bits of a frame; the clock is left high afterwards.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (10) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    // Full frame; measures clk edges from the 11th fall to the result pulse
    // and whether the pulse is one cycle wide.
    task automatic send_byte(input logic [7:0] b, input logic bad_par,
                             output int lat, output logic gv, output logic ge,
                             output logic narrow);
        logic [10:0] f;
        logic        got;
        f = make_frame(b, bad_par);
        send_bits(f, 10);
        ps2_data = f[10];
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        got = 1'b0; lat = 0; gv = 1'b0; ge = 1'b0; narrow = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(posedge clk); #1;
            if (frame_valid || frame_err) begin
                got = 1'b1; lat = k; gv = frame_valid; ge = frame_err;
            end
        end
        if (got) begin
            @(posedge clk); #1;
            narrow = !frame_valid && !frame_err;
        end
        @(negedge clk);
        repeat (4) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_btn = 1'b0;
        #1;
        check("rst_plyr", 32'(plyr_input), 32'h000);
        check("rst_scan", 32'(scan_code), 32'h00);
        check("rst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int   lat;
        logic gv, ge, narrow;
        int   v0, e0;

        checks = 0; errors = 0;
        valid_cnt = 0; err_cnt = 0; overlap_cnt = 0;
        rst_btn = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;

        vecs[0]  = '{8'h1A, 1'b0, 12'h001, 8'h1A, 1'b1};
        vecs[1]  = '{8'hF0, 1'b0, 12'h001, 8'hF0, 1'b1};
        vecs[2]  = '{8'h1A, 1'b0, 12'h000, 8'h1A, 1'b1};
        vecs[3]  = '{8'hE0, 1'b0, 12'h000, 8'hE0, 1'b1};
        vecs[4]  = '{8'h75, 1'b0, 12'h010, 8'h75, 1'b1};
        vecs[5]  = '{8'hE0, 1'b0, 12'h010, 8'hE0, 1'b1};
        vecs[6]  = '{8'hF0, 1'b0, 12'h010, 8'hF0, 1'b1};
        vecs[7]  = '{8'h75, 1'b0, 12'h000, 8'h75, 1'b1};
        vecs[8]  = '{8'hE0, 1'b0, 12'h000, 8'hE0, 1'b1};
        vecs[9]  = '{8'h5A, 1'b0, 12'h000, 8'h5A, 1'b1};
        vecs[10] = '{8'h1C, 1'b1, 12'h000, 8'h5A, 1'b0};
        vecs[11] = '{8'hF0, 1'b0, 12'h000, 8'hF0, 1'b1};
        vecs[12] = '{8'h1C, 1'b1, 12'h000, 8'hF0, 1'b0};
        vecs[13] = '{8'h1C, 1'b0, 12'h002, 8'h1C, 1'b1};
        vecs[14] = '{8'h5A, 1'b0, 12'h00A, 8'h5A, 1'b1};
        vecs[15] = '{8'h22, 1'b0, 12'h10A, 8'h22, 1'b1};
        vecs[16] = '{8'h1B, 1'b0, 12'h30A, 8'h1B, 1'b1};
        vecs[17] = '{8'h15, 1'b0, 12'h70A, 8'h15, 1'b1};
        vecs[18] = '{8'h1D, 1'b0, 12'hF0A, 8'h1D, 1'b1};
        vecs[19] = '{8'h59, 1'b0, 12'hF0E, 8'h59, 1'b1};
        vecs[20] = '{8'hE0, 1'b0, 12'hF0E, 8'hE0, 1'b1};
        vecs[21] = '{8'h72, 1'b0, 12'hF2E, 8'h72, 1'b1};
        vecs[22] = '{8'hE0, 1'b0, 12'hF2E, 8'hE0, 1'b1};
        vecs[23] = '{8'h6B, 1'b0, 12'hF6E, 8'h6B, 1'b1};
        vecs[24] = '{8'hE0, 1'b0, 12'hF6E, 8'hE0, 1'b1};
        vecs[25] = '{8'h74, 1'b0, 12'hFEE, 8'h74, 1'b1};
        vecs[26] = '{8'h1A, 1'b0, 12'hFEF, 8'h1A, 1'b1};
        vecs[27] = '{8'h1A, 1'b0, 12'hFEF, 8'h1A, 1'b1};
        vecs[28] = '{8'hE0, 1'b0, 12'hFEF, 8'hE0, 1'b1};
        vecs[29] = '{8'hF0, 1'b0, 12'hFEF, 8'hF0, 1'b1};
        vecs[30] = '{8'h74, 1'b1, 12'hFEF, 8'hF0, 1'b0};
        vecs[31] = '{8'h74, 1'b0, 12'hFEF, 8'h74, 1'b1};

        apply_reset();

        foreach (vecs[i]) begin
            v0 = valid_cnt; e0 = err_cnt;
            send_byte(vecs[i].code, vecs[i].bad_par, lat, gv, ge, narrow);
            check("latency", 32'(lat), 32'd4);
            check("pulse_kind", {30'd0, gv, ge}, {30'd0, vecs[i].exp_valid, ~vecs[i].exp_valid});
            check("pulse_width", 32'(narrow), 32'd1);
            check("valid_count", 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check("err_count", 32'(err_cnt - e0), 32'(!vecs[i].exp_valid));
            check("plyr_input", 32'(plyr_input), 32'(vecs[i].exp_plyr));
            check("scan_code", 32'(scan_code), 32'(vecs[i].exp_scan));
            $display("vec %0d: byte %02h badpar %0d -> plyr %03h scan %02h valid %0d err %0d lat %0d",
                     i, vecs[i].code, vecs[i].bad_par, plyr_input, scan_code, gv, ge, lat);
        end

        // Reset in the middle of a frame, then a clean frame afterwards.
        send_bits(make_frame(8'h1C, 1'b0), 5);
        ps2_data = 1'b0;
        apply_reset();
        send_byte(8'h1A, 1'b0, lat, gv, ge, narrow);
        check("post_rst_plyr", 32'(plyr_input), 32'h001);
        check("post_rst_valid", 32'(gv), 32'd1);
        $display("reset mid-frame: plyr %03h scan %02h", plyr_input, scan_code);

        // Timeout: six bits then silence.
        apply_reset();
        v0 = valid_cnt; e0 = err_cnt;
        send_bits(make_frame(8'h5A, 1'b0), 6);
        repeat (150) @(negedge clk);
        check("timeout_err", 32'(err_cnt - e0), 32'd1);
        check("timeout_valid", 32'(valid_cnt - v0), 32'd0);
        check("timeout_plyr", 32'(plyr_input), 32'h000);
        send_byte(8'h5A, 1'b0, lat, gv, ge, narrow);
        check("after_to_plyr", 32'(plyr_input), 32'h008);
        check("after_to_valid", 32'(gv), 32'd1);
        $display("timeout: errs %0d then plyr %03h", err_cnt - e0, plyr_input);

        check("overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
